// File: rtl/memory_pkg.sv
// Shared constants, state encoding and saturation helper for the reverb datapath.
// Also used by the memory controller gain path.
package memory_pkg;

  localparam int DATA_W    = 16;
  localparam int ACC_W     = 40;
  localparam int FRAC_BITS = 15;
  localparam logic [15:0] MAX_TAPS = 16'h00FF;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_WAIT_COEF = 3'd1;
  localparam logic [2:0] ST_WAIT_SAMP = 3'd2;
  localparam logic [2:0] ST_MAC       = 3'd3;
  localparam logic [2:0] ST_SCALE     = 3'd4;
  localparam logic [2:0] ST_MIX       = 3'd5;

  // Clamp a wide signed value into the Q1.15 range.
  function automatic logic [15:0] sat16(input logic signed [47:0] x);
    logic [15:0] r;
    if (x > 48'sd32767)       r = 16'h7FFF;
    else if (x < -48'sd32768) r = 16'h8000;
    else                      r = x[15:0];
    return r;
  endfunction

endpackage

// File: rtl/reverb_mac_if.sv
// Word stream from the memory controller: alternating coefficient / delayed-sample words.
// Handshake: a word transfers on a clock edge where mem_valid and mem_ready are both high.
interface reverb_mac_if;
  logic        mem_valid;
  logic        mem_is_coef;
  logic [15:0] mem_data;
  logic        mem_ready;

  modport master (output mem_valid, output mem_is_coef, output mem_data, input mem_ready);
  modport slave  (input mem_valid, input mem_is_coef, input mem_data, output mem_ready);
endinterface

// File: rtl/sat_mul_q15.sv
// Signed Q1.15 multiply with arithmetic rescale and 16-bit saturation.
module sat_mul_q15
  import memory_pkg::*;
(
  input  logic signed [15:0] a,
  input  logic signed [15:0] b,
  output logic        [15:0] y
);
  logic signed [31:0] prod;
  logic signed [31:0] shifted;

  assign prod    = a * b;
  assign shifted = prod >>> FRAC_BITS;
  assign y       = sat16({{16{shifted[31]}}, shifted});
endmodule

// File: rtl/reverb_mac.sv
// Convolution MAC: accumulates coef*sample pairs per frame, applies wet gain,
// mixes in the dry sample and emits one output word per frame.
module reverb_mac
  import memory_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        sample_strobe,
  input  logic [15:0] dry_in,
  input  logic [15:0] taps,
  input  logic [15:0] gain,
  input  logic        err_clr,
  reverb_mac_if.slave mem,
  output logic        out_valid,
  output logic [15:0] out_data,
  output logic        busy,
  output logic        overrun,
  output logic        seq_err,
  output logic [2:0]  dbg_state
);
  logic [2:0]              state_q, state_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic [15:0]             tap_cnt_q, tap_cnt_d;
  logic [15:0]             taps_q, taps_d;
  logic signed [15:0]      coef_q, coef_d, samp_q, samp_d;
  logic signed [15:0]      dry_q, dry_d, gain_q, gain_d, wet_q, wet_d;
  logic [15:0]             out_data_q, out_data_d;
  logic                    out_valid_q, out_valid_d;
  logic                    overrun_q, overrun_d, seq_err_q, seq_err_d;

  logic                    accept, bad_word;
  logic [15:0]             tap_next;
  logic signed [31:0]      prod;
  logic signed [ACC_W-1:0] acc_shift;
  logic [15:0]             wet_gain;

  assign mem.mem_ready = (state_q == ST_WAIT_COEF) || (state_q == ST_WAIT_SAMP);
  assign accept        = mem.mem_valid && mem.mem_ready;
  assign bad_word      = accept && (((state_q == ST_WAIT_COEF) && !mem.mem_is_coef) ||
                                    ((state_q == ST_WAIT_SAMP) &&  mem.mem_is_coef));
  assign tap_next      = tap_cnt_q + 16'd1;
  assign prod          = coef_q * samp_q;
  assign acc_shift     = acc_q >>> FRAC_BITS;

  sat_mul_q15 u_gain_mul (.a(wet_q), .b(gain_q), .y(wet_gain));

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    tap_cnt_d   = tap_cnt_q;
    taps_d      = taps_q;
    coef_d      = coef_q;
    samp_d      = samp_q;
    dry_d       = dry_q;
    gain_d      = gain_q;
    wet_d       = wet_q;
    out_data_d  = out_data_q;
    out_valid_d = 1'b0;
    // Error flags: a new event in the same cycle as err_clr keeps the flag set.
    overrun_d   = (sample_strobe && (state_q != ST_IDLE)) || (overrun_q && !err_clr);
    seq_err_d   = bad_word || (seq_err_q && !err_clr);

    case (state_q)
      ST_IDLE: begin
        if (sample_strobe) begin
          dry_d     = dry_in;
          gain_d    = gain;
          taps_d    = (taps > MAX_TAPS) ? MAX_TAPS : taps;
          acc_d     = '0;
          tap_cnt_d = '0;
          state_d   = (taps == 16'd0) ? ST_SCALE : ST_WAIT_COEF;
        end
      end
      ST_WAIT_COEF: begin
        if (accept && mem.mem_is_coef) begin
          coef_d  = mem.mem_data;
          state_d = ST_WAIT_SAMP;
        end
      end
      ST_WAIT_SAMP: begin
        if (accept && !mem.mem_is_coef) begin
          samp_d  = mem.mem_data;
          state_d = ST_MAC;
        end
      end
      ST_MAC: begin
        acc_d     = acc_q + {{(ACC_W-32){prod[31]}}, prod};
        tap_cnt_d = tap_next;
        state_d   = (tap_next == taps_q) ? ST_SCALE : ST_WAIT_COEF;
      end
      ST_SCALE: begin
        wet_d   = sat16({{(48-ACC_W){acc_shift[ACC_W-1]}}, acc_shift});
        state_d = ST_MIX;
      end
      ST_MIX: begin
        out_data_d  = sat16({{32{dry_q[15]}}, dry_q} + {{32{wet_gain[15]}}, wet_gain});
        out_valid_d = 1'b1;
        state_d     = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      acc_q       <= '0;
      tap_cnt_q   <= '0;
      taps_q      <= '0;
      coef_q      <= '0;
      samp_q      <= '0;
      dry_q       <= '0;
      gain_q      <= '0;
      wet_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
      seq_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      tap_cnt_q   <= tap_cnt_d;
      taps_q      <= taps_d;
      coef_q      <= coef_d;
      samp_q      <= samp_d;
      dry_q       <= dry_d;
      gain_q      <= gain_d;
      wet_q       <= wet_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      overrun_q   <= overrun_d;
      seq_err_q   <= seq_err_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign busy      = (state_q != ST_IDLE);
  assign overrun   = overrun_q;
  assign seq_err   = seq_err_q;
  assign dbg_state = state_q;
endmodule

// File: tb/tb_reverb_mac.sv
// Directed and randomized frames through reverb_mac with an expected-output queue.
module tb_reverb_mac;
  import memory_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        sample_strobe = 1'b0;
  logic [15:0] dry_in = '0, taps = '0, gain = '0;
  logic        err_clr = 1'b0;
  logic        out_valid, busy, overrun, seq_err;
  logic [15:0] out_data;
  logic [2:0]  dbg_state;

  reverb_mac_if mem_if ();

  reverb_mac dut (
    .clk(clk), .rst(rst), .sample_strobe(sample_strobe), .dry_in(dry_in),
    .taps(taps), .gain(gain), .err_clr(err_clr), .mem(mem_if),
    .out_valid(out_valid), .out_data(out_data), .busy(busy),
    .overrun(overrun), .seq_err(seq_err), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int out_cnt = 0;
  logic [15:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Output monitor: every out_valid pulse consumes one expected word.
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      out_cnt++;
      if (exp_q.size() == 0) check("unexpected_out", 32'(out_data), 32'hFFFF_FFFF);
      else                   check("out_data", 32'(out_data), 32'(exp_q.pop_front()));
    end
  end

  function automatic logic [15:0] clamp16(input longint v);
    if (v > 32767)  return 16'h7FFF;
    if (v < -32768) return 16'h8000;
    return v[15:0];
  endfunction

  function automatic logic [15:0] model(input logic [15:0] d, input logic [15:0] g, input int n,
                                        input logic [15:0] c[4], input logic [15:0] s[4]);
    longint acc = 0;
    shortint sc, ss, sw, sg, sd, sp;
    for (int i = 0; i < n; i++) begin
      sc = c[i]; ss = s[i];
      acc += longint'(sc) * longint'(ss);
    end
    sw = clamp16(acc >>> 15);
    sg = g;
    sp = clamp16((longint'(sw) * longint'(sg)) >>> 15);
    sd = d;
    return clamp16(longint'(sd) + longint'(sp));
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic strobe(input logic [15:0] d, input logic [15:0] t, input logic [15:0] g);
    sample_strobe = 1'b1; dry_in = d; taps = t; gain = g;
    tick();
    sample_strobe = 1'b0; dry_in = $urandom_range(0, 65535); taps = 16'd2; gain = '0;
  endtask

  task automatic send_word(input logic c, input logic [15:0] d);
    int n = 0;
    mem_if.mem_valid = 1'b1; mem_if.mem_is_coef = c; mem_if.mem_data = d;
    while (!mem_if.mem_ready && n < 50) begin tick(); n++; end
    check("word_timeout", 32'(n < 50), 32'd1);
    tick();
    mem_if.mem_valid = 1'b0;
  endtask

  task automatic send_pair(input logic [15:0] c, input logic [15:0] s);
    send_word(1'b1, c);
    send_word(1'b0, s);
  endtask

  task automatic wait_done();
    int n = 0;
    while (busy && n < 2000) begin tick(); n++; end
    check("frame_timeout", 32'(n < 2000), 32'd1);
    tick(); tick();
  endtask

  logic [15:0] rc[4], rs[4], rd, rg;
  int rn, base;

  initial begin
    mem_if.mem_valid = 1'b0; mem_if.mem_is_coef = 1'b0; mem_if.mem_data = '0;
    rst = 1'b1;
    tick(); tick();
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_out_data", 32'(out_data), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_mem_ready", 32'(mem_if.mem_ready), 0);
    check("rst_flags", {30'd0, overrun, seq_err}, 0);
    check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    rst = 1'b0;
    tick();

    // Single tap with latency check.
    exp_q.push_back(16'h1FFF);
    strobe(16'h0000, 16'd1, 16'h7FFF);
    check("busy_frame", 32'(busy), 1);
    send_pair(16'h4000, 16'h4000);
    tick(); tick();
    check("lat_early", 32'(out_valid), 0);
    tick();
    check("lat_valid", 32'(out_valid), 1);
    check("lat_data", 32'(out_data), 32'h1FFF);
    tick();
    check("lat_pulse", 32'(out_valid), 0);
    check("idle_busy", 32'(busy), 0);

    // Positive and negative saturation.
    exp_q.push_back(16'h7FFF);
    strobe(16'h7FFF, 16'd4, 16'h7FFF);
    repeat (4) send_pair(16'h7FFF, 16'h7FFF);
    wait_done();
    exp_q.push_back(16'h8000);
    strobe(16'h8000, 16'd4, 16'h7FFF);
    repeat (4) send_pair(16'h8001, 16'h7FFF);
    wait_done();

    // Zero taps: straight to SCALE, memory side never ready.
    exp_q.push_back(16'h1234);
    mem_if.mem_valid = 1'b1; mem_if.mem_is_coef = 1'b1; mem_if.mem_data = 16'h7FFF;
    strobe(16'h1234, 16'd0, 16'h7FFF);
    check("zt_ready_scale", 32'(mem_if.mem_ready), 0);
    tick();
    check("zt_ready_mix", 32'(mem_if.mem_ready), 0);
    check("zt_not_yet", 32'(out_valid), 0);
    tick();
    check("zt_valid", 32'(out_valid), 1);
    check("zt_seq_err", 32'(seq_err), 0);
    mem_if.mem_valid = 1'b0;
    tick();

    // Sequence error with a coincident err_clr: the set wins.
    exp_q.push_back(16'h1FFF);
    strobe(16'h0000, 16'd1, 16'h7FFF);
    err_clr = 1'b1;
    send_word(1'b0, 16'h5555);
    err_clr = 1'b0;
    check("seq_err_set", 32'(seq_err), 1);
    send_pair(16'h4000, 16'h4000);
    wait_done();
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    check("seq_err_clr", 32'(seq_err), 0);

    // Overrun: second strobe mid-frame is ignored, frame still runs three taps.
    base = out_cnt;
    exp_q.push_back(16'h60FF);
    strobe(16'h0100, 16'd3, 16'h7FFF);
    send_pair(16'h4000, 16'h4000);
    strobe(16'h7000, 16'd0, 16'h0000);
    check("overrun_set", 32'(overrun), 1);
    check("overrun_busy", 32'(busy), 1);
    send_pair(16'h4000, 16'h4000);
    send_pair(16'h4000, 16'h4000);
    wait_done();
    check("overrun_one_out", 32'(out_cnt - base), 1);
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    check("overrun_clr", 32'(overrun), 0);

    // Reset mid-frame during WAIT_SAMP of tap 2.
    base = out_cnt;
    strobe(16'h0100, 16'd3, 16'h7FFF);
    send_pair(16'h4000, 16'h4000);
    send_word(1'b1, 16'h4000);
    check("pre_rst_state", 32'(dbg_state), 32'(ST_WAIT_SAMP));
    #2 rst = 1'b1;
    #1;
    check("mid_rst_state", 32'(dbg_state), 32'(ST_IDLE));
    check("mid_rst_outs", {13'd0, out_valid, busy, mem_if.mem_ready, out_data}, 0);
    tick(); tick(); tick();
    rst = 1'b0;
    tick(); tick(); tick();
    check("mid_rst_no_out", 32'(out_cnt - base), 0);
    exp_q.push_back(16'h1FFF);
    strobe(16'h0000, 16'd1, 16'h7FFF);
    send_pair(16'h4000, 16'h4000);
    wait_done();

    // Taps clamp: 0xFFFF requests run exactly 255 pairs.
    exp_q.push_back(16'h01FD);
    strobe(16'h0000, 16'hFFFF, 16'h7FFF);
    repeat (255) send_pair(16'h0100, 16'h0100);
    wait_done();
    check("clamp_idle", 32'(dbg_state), 32'(ST_IDLE));

    // Randomized frames against the reference model.
    for (int f = 0; f < 6; f++) begin
      rn = $urandom_range(1, 4);
      rd = $urandom_range(0, 65535);
      rg = $urandom_range(0, 65535);
      for (int i = 0; i < 4; i++) begin
        rc[i] = $urandom_range(0, 65535);
        rs[i] = $urandom_range(0, 65535);
      end
      exp_q.push_back(model(rd, rg, rn, rc, rs));
      strobe(rd, 16'(rn), rg);
      for (int i = 0; i < rn; i++) send_pair(rc[i], rs[i]);
      wait_done();
    end

    check("queue_empty", 32'(exp_q.size()), 0);
    check("no_stray_flags", {30'd0, overrun, seq_err}, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/reverb_mac.md
Name: reverb_mac

Overview:
- Convolution multiply-accumulate stage directly downstream of the memory controller.
- Consumes the alternating impulse-coefficient / delayed-sample words the controller reads from SRAM or off-chip memory.
- Accumulates one convolution sum per ADC sample, scales it by the wet gain, and mixes in the dry input.
- Presents one 16-bit output sample per frame to the DAC path.

Parameters:
- DATA_W, 16, sample/coefficient/gain width, signed Q1.15.
- ACC_W, 40, accumulator width; covers 256 full-scale taps without wrap.
- FRAC_BITS, 15, right shift applied to the accumulator and the gain product.
- MAX_TAPS, 16'h00FF, upper clamp on the taps input.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- sample_strobe  in  1  one-cycle pulse, clk-synchronous, marks a new ADC sample and frame start.
- dry_in  in  16  current ADC sample, signed.
- taps  in  16  impulse length for this frame.
- gain  in  16  wet gain, signed Q1.15.
- mem_valid  in  1  mem_data holds a word.
- mem_is_coef  in  1  1 = impulse coefficient, 0 = delayed sample.
- mem_data  in  16  word read by the memory controller.
- mem_ready  out  1  MAC can accept a word.
- out_valid  out  1  one-cycle pulse, out_data is new.
- out_data  out  16  mixed output sample, signed.
- busy  out  1  frame in progress.
- overrun  out  1  sticky; strobe arrived while busy.
- seq_err  out  1  sticky; word type did not match the expected type.
- err_clr  in  1  clears overrun and seq_err.

Behaviour:
- Reset (async, rst=1): state IDLE; acc, tap_cnt, coef_r, out_data = 0; mem_ready, out_valid, busy, overrun, seq_err = 0. Reset mid-frame aborts the frame and produces no out_valid.
- States: IDLE, WAIT_COEF, WAIT_SAMP, MAC, SCALE, MIX.
- IDLE:
  - On sample_strobe: latch dry_in, gain, and taps_r = min(taps, MAX_TAPS); acc=0, tap_cnt=0.
  - Go to SCALE if taps_r==0, else WAIT_COEF.
- A word is accepted when mem_valid & mem_ready. mem_ready=1 only in WAIT_COEF and WAIT_SAMP.
- WAIT_COEF:
  - Accepted word with mem_is_coef=1: coef_r <= mem_data, go to WAIT_SAMP.
  - Accepted word with mem_is_coef=0: discard, set seq_err, stay.
- WAIT_SAMP:
  - Accepted word with mem_is_coef=0: samp_r <= mem_data, go to MAC.
  - Accepted word with mem_is_coef=1: discard, set seq_err, stay.
- MAC (1 cycle):
  - acc <= acc + sign_extend(coef_r*samp_r, ACC_W); product is 32-bit signed, full precision.
  - tap_cnt <= tap_cnt+1.
  - If tap_cnt+1 == taps_r go to SCALE, else WAIT_COEF.
- SCALE (1 cycle): wet = acc >>> FRAC_BITS (arithmetic), saturated to [0x8000, 0x7FFF].
- MIX (1 cycle):
  - out_data <= sat16(dry_r + sat16((wet*gain_r) >>> FRAC_BITS)).
  - out_valid=1 for this cycle only; return to IDLE.
- Latency: out_valid asserts 2 cycles after the last MAC cycle (2 cycles after the strobe when taps=0). The MAC never stalls the memory side beyond 1 cycle per pair.
- busy=1 in every state except IDLE.
- sample_strobe when not IDLE: set overrun, ignore the strobe, continue the current frame; no dry_in/taps/gain relatch.
- Inputs that change during a frame have no effect.
- sample_strobe in the same cycle as MIX: state is not IDLE, so overrun is set and the strobe is ignored.
- err_clr and a simultaneous set event: set wins.
- mem_valid in IDLE/MAC/SCALE/MIX: ignored, no error.

Decomposition:
- Shared package memory_pkg holds:
  - DATA_W, ACC_W, FRAC_BITS, MAX_TAPS defaults.
  - The state encoding constants.
  - The sat16 saturation function, which the memory controller gain path also uses.
- One sub-module, sat_mul_q15: signed 16x16 multiply, arithmetic shift by FRAC_BITS, saturate to 16 bits. Used once in MIX; reusable elsewhere.
- The accumulator stays inline.

Test Plan:
- Single tap: taps=1, gain=0x7FFF, dry_in=0, pair (coef 0x4000, samp 0x4000) -> out_data=0x1FFF, out_valid one cycle, 2 cycles after the MAC.
- Saturation: taps=4, four pairs (0x7FFF, 0x7FFF), gain=0x7FFF, dry_in=0x7FFF -> wet saturates to 0x7FFF, out_data=0x7FFF. Repeat with negated coefficients (0x8001) and dry_in=0x8000 -> out_data=0x8000.
- Zero taps: taps=0, dry_in=0x1234 -> out_data=0x1234 two cycles after the strobe; mem_ready never asserted.
- Sequence error: in WAIT_COEF, feed a sample word (is_coef=0, 0x5555) then the correct pair (coef 0x4000, samp 0x4000), taps=1, gain=0x7FFF -> seq_err=1, out_data=0x1FFF (bad word discarded). err_clr -> seq_err=0.
- Overrun: taps=3, strobe again after one pair -> overrun=1, frame completes with 3 taps, exactly one out_valid.
- Reset mid-frame: assert rst during WAIT_SAMP of tap 2 -> all outputs 0, state IDLE, no out_valid. The next strobe runs a clean frame.
